// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key code type,
// column strobe patterns and the row priority encoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    typedef logic [3:0] key_code_t;

    localparam logic [3:0] COL_STROBE [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    // Index of the lowest active-low row; only meaningful when some row is low.
    function automatic logic [1:0] first_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous keypad rows; resets to all-ones so an
// unpressed keypad is what the scanner sees out of reset.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobing, per-scan capture, press/release debounce and
// a valid/ready key output. Define KEYPAD_REPEAT_EN to enable auto-repeat while held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 5,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic      clk,
    input  logic      rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output key_code_t key_code,
    output logic      key_valid,
    input  logic      key_ready,
    output logic      key_overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       w_rows;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic             r_cap_hit;
    key_code_t        r_cap_code;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    key_code_t        r_cand;
    key_code_t        w_cand_next;
    logic             w_emit;
    key_code_t        w_emit_code;
    key_code_t        r_key_code;
    logic             r_key_valid;
    logic             r_overrun;

    keypad_sync #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (row_in),
        .o_q (w_rows)
    );

    logic      w_slot_end;
    logic      w_scan_end;
    logic      w_col_hit;
    key_code_t w_col_code;
    logic      w_scan_hit;
    key_code_t w_scan_code;

    assign w_slot_end  = (r_div == DIV_LAST);
    assign w_scan_end  = w_slot_end && (r_col == 2'd3);
    assign w_col_hit   = (w_rows != 4'hF);
    assign w_col_code  = {first_low_row(w_rows), r_col};
    assign w_scan_hit  = r_cap_hit || w_col_hit;
    assign w_scan_code = r_cap_hit ? r_cap_code : w_col_code;
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign col_out     = COL_STROBE[r_col];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_col <= 2'd0;
        end else if (w_slot_end) begin
            r_div <= '0;
            r_col <= r_col + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Earliest column wins, so later columns only fill an empty capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_hit  <= 1'b0;
            r_cap_code <= '0;
        end else if (w_scan_end) begin
            r_cap_hit  <= 1'b0;
            r_cap_code <= '0;
        end else if (w_slot_end && !r_cap_hit && w_col_hit) begin
            r_cap_hit  <= 1'b1;
            r_cap_code <= w_col_code;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_MAX_C   = REP_W'(REP_MAX);
    localparam logic [REP_W-1:0] REP_DELAY_C = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RATE_C  = REP_W'(REPEAT_RATE);

    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_rep_next;
    logic [REP_W-1:0] w_rep_inc;
    logic             r_rep_armed;
    logic             w_rep_armed_next;

    assign w_rep_inc = (r_rep == REP_MAX_C) ? r_rep : r_rep + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep       <= '0;
            r_rep_armed <= 1'b0;
        end else begin
            r_rep       <= w_rep_next;
            r_rep_armed <= w_rep_armed_next;
        end
    end
`else
    logic w_unused_repeat;
    assign w_unused_repeat = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cand  <= w_cand_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        w_emit       = 1'b0;
        w_emit_code  = r_cand;
`ifdef KEYPAD_REPEAT_EN
        w_rep_next       = r_rep;
        w_rep_armed_next = r_rep_armed;
`endif
        if (w_scan_end) begin
            case (r_state)
                IDLE: begin
                    if (w_scan_hit) begin
                        w_cand_next = w_scan_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            w_emit       = 1'b1;
                            w_emit_code  = w_scan_code;
                            w_state_next = HELD;
                            w_cnt_next   = '0;
                        end else begin
                            w_state_next = DEBOUNCE;
                            w_cnt_next   = CNT_ONE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (w_scan_hit && (w_scan_code == r_cand)) begin
                        if (w_cnt_inc == CNT_MAX) begin
                            w_emit       = 1'b1;
                            w_state_next = HELD;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end else begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end
                end
                HELD: begin
                    if (!w_scan_hit) begin
                        w_state_next = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                        w_cnt_next   = (DEBOUNCE_SCANS == 1) ? '0 : CNT_ONE;
`ifdef KEYPAD_REPEAT_EN
                        w_rep_next       = '0;
                        w_rep_armed_next = 1'b0;
                    end else if (w_rep_inc == (r_rep_armed ? REP_RATE_C : REP_DELAY_C)) begin
                        w_emit           = 1'b1;
                        w_rep_next       = '0;
                        w_rep_armed_next = 1'b1;
                    end else begin
                        w_rep_next = w_rep_inc;
`endif
                    end
                end
                RELEASE: begin
                    // A returning hit is the same key still bouncing, not a new press.
                    if (w_scan_hit) begin
                        w_state_next = HELD;
                        w_cnt_next   = '0;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // A pending key is never overwritten; a concurrent handshake frees the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_emit) begin
                if (!r_key_valid || key_ready) begin
                    r_key_code  <= w_emit_code;
                    r_key_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_key_valid && key_ready) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_overrun = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-clock scans)
// and a behavioural keypad matrix driven from a 16-bit key vector.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_overrun;
    logic [15:0] keys;

    int n_assert = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_ovr    = 0;
    logic [3:0] last_code = 4'h0;

    always #5 clk = ~clk;

    // Key bit index = {row, col}; a pressed key pulls its row low while its column strobes.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if ((keys[r*4 +: 4] & ~col_out) != 4'h0) begin
                row_in[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_DELAY   (3),
        .REPEAT_RATE    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_overrun (key_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_valid) begin
                n_valid++;
                last_code = key_code;
            end
            if (key_overrun) n_ovr++;
        end
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_ovr   = 0;
    endtask

    // Returns at the first negedge after col_out wraps from column 3 to column 0.
    task automatic align();
        logic [3:0] prev;
        prev = col_out;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (prev == 4'h7 && col_out == 4'hE) return;
            prev = col_out;
        end
        n_assert++;
        n_fail++;
        $display("FAIL align: observed no column wrap within 64 clocks, required a wrap");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        keys      = 16'h0;
        key_ready = 1'b1;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_col", col_out, 4'hE);
        check("reset_valid", key_valid, 0);
        check("reset_overrun", key_overrun, 0);
        check("reset_code", key_code, 0);
        rst = 1'b0;
        $display("step: reset released");

        // Single press of row 2 / column 2
        align();
        clear_counts();
        keys[10] = 1'b1;
        run(31);
        check("press_not_early", n_valid, 0);
        run(1);
        check("press_valid", key_valid, 1);
        check("press_code", key_code, 4'hA);
        run(1);
        check("press_one_cycle", key_valid, 0);
        run(15);
        keys = 16'h0;
        run(64);
        check("press_once", n_valid, 1);
        check("press_no_overrun", n_ovr, 0);
        $display("step: single press, valid cycles %0d", n_valid);

        // Bouncing row 0 in column 1, then stable
        align();
        clear_counts();
        for (int j = 0; j < 80; j++) begin
            keys[1] = ((j / 5) % 2 == 0);
            run(1);
        end
        check("bounce_no_emit", n_valid, 0);
        keys[1] = 1'b1;
        run(32);
        check("bounce_stable_valid", key_valid, 1);
        check("bounce_stable_code", key_code, 4'h1);
        run(16);
        keys = 16'h0;
        run(64);
        check("bounce_once", n_valid, 1);
        $display("step: bounce, valid cycles %0d", n_valid);

        // Backpressure: second key dropped while first is pending
        key_ready = 1'b0;
        align();
        clear_counts();
        keys = 16'h0020;
        run(40);
        check("bp_first_valid", key_valid, 1);
        check("bp_first_code", key_code, 4'h5);
        keys = 16'h0;
        run(40);
        keys = 16'h0040;
        run(40);
        check("bp_overrun_pulses", n_ovr, 1);
        check("bp_still_valid", key_valid, 1);
        check("bp_code_retained", key_code, 4'h5);
        key_ready = 1'b1;
        run(1);
        check("bp_valid_drops", key_valid, 0);
        keys = 16'h0;
        run(80);
        check("bp_no_more_overrun", n_ovr, 1);
        check("bp_idle_after", key_valid, 0);
        $display("step: backpressure, overrun pulses %0d", n_ovr);

        // Rows 3 and 1 in column 0 together
        align();
        clear_counts();
        keys = 16'h1010;
        run(40);
        check("multi_once", n_valid, 1);
        check("multi_code", last_code, 4'h4);
        keys = 16'h1000;
        run(24);
        check("multi_partial_release", n_valid, 1);
        keys = 16'h0;
        run(64);
        check("multi_full_release", n_valid, 1);
        $display("step: simultaneous keys, code %0h", last_code);

`ifdef KEYPAD_REPEAT_EN
        align();
        clear_counts();
        keys = 16'h8000;
        run(150);
        keys = 16'h0;
        check("repeat_count", n_valid, 4);
        check("repeat_code", last_code, 4'hF);
        run(64);
        check("repeat_after_release", n_valid, 4);
        $display("step: auto-repeat, emits %0d", n_valid);
`endif

        // Reset with a key pending
        key_ready = 1'b0;
        align();
        clear_counts();
        keys = 16'h0008;
        run(40);
        check("midrst_pending", key_valid, 1);
        check("midrst_pending_code", key_code, 4'h3);
        check("midrst_col_before", col_out, 4'hB);
        rst = 1'b1;
        #1;
        check("midrst_col", col_out, 4'hE);
        check("midrst_valid", key_valid, 0);
        check("midrst_overrun", key_overrun, 0);
        check("midrst_code", key_code, 0);
        @(negedge clk);
        rst  = 1'b0;
        keys = 16'h0;
        clear_counts();
        run(64);
        check("midrst_quiet", n_valid + n_ovr, 0);
        $display("step: mid-operation reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad, debounces presses, and delivers one 4-bit key code per press over a valid/ready handshake. It is the input-side counterpart of the multiplexed seven-segment display driver. It drives active-low column strobes one at a time and reads active-low row returns. It sits between the keypad pins and the ATM control FSM, which consumes key codes for PIN and amount entry.

## Interface
- SCAN_DIV, 1000: clocks per column slot; minimum 4.
- DEBOUNCE_SCANS, 5: consecutive full scans required to accept a press or a release; minimum 1.
- REPEAT_DELAY, 50: full scans held before the first auto-repeat; used only with the repeat macro.
- REPEAT_RATE, 10: full scans between later auto-repeats; used only with the repeat macro.
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- row_in  input  4  keypad rows, active-low, pulled up, asynchronous to clk
- col_out  output  4  column strobes, one-hot-low
- key_code  output  4  {row_idx[1:0], col_idx[1:0]}; stable while key_valid is high
- key_valid  output  1  key available
- key_ready  input  1  consumer accepts the key
- key_overrun  output  1  one-cycle pulse when a key is dropped

## Operation
- Reset values:
  - col_out = 4'hE (column 0)
  - key_code = 0, key_valid = 0, key_overrun = 0
  - FSM in IDLE; all counters 0
- Scanning:
  - row_in passes through a 2-flop synchronizer.
  - A prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 the synchronized rows are sampled, then col_out advances to the next column: 0,1,2,3,0…
- Per-scan capture:
  - Within a full scan, the first pressed key found wins. Columns are searched in order 0..3; within a column, the lowest row wins.
  - At the column-3 sample, scan_hit and scan_code are finalized, the FSM evaluates once, and the capture registers clear.
- FSM states, evaluated once per full scan:
  - IDLE: if hit, go to DEBOUNCE with cand = code and cnt = 1. If DEBOUNCE_SCANS = 1, emit immediately and go to HELD.
  - DEBOUNCE:
    - hit with code == cand: cnt++. When cnt reaches DEBOUNCE_SCANS, emit cand and go to HELD.
    - miss or different code: go to IDLE, cnt = 0.
  - HELD:
    - any hit: stay (repeat logic below).
    - miss: go to RELEASE, cnt = 1.
  - RELEASE:
    - miss: cnt++. At DEBOUNCE_SCANS, go to IDLE.
    - hit: return to HELD. This is not a new press.
- Emit rules:
  - If key_valid = 0, or the current cycle is a handshake (key_valid && key_ready), load key_code and set key_valid.
  - Otherwise the new key is dropped, key_overrun pulses for 1 cycle, and the pending code is retained.
- Handshake:
  - key_valid stays high until the first clk edge with key_ready = 1, and deasserts the next cycle unless an emit coincides.
  - key_ready while key_valid = 0 is ignored.
- Counters are sized with $clog2(max+1) and saturate; they never wrap.

## Timing
- Column slot = SCAN_DIV clocks; full scan = 4*SCAN_DIV clocks.
- Row synchronizer latency is 2 clocks. Because sampling happens at the end of the slot, this is hidden whenever SCAN_DIV >= 4.
- Press latency: key_valid rises 1 clock after the column-3 sample of the DEBOUNCE_SCANS-th consecutive hit scan.
- Release: a new press is accepted no sooner than DEBOUNCE_SCANS miss scans after release.
- A second key pressed while one is held produces nothing until full release.
- rst mid-operation immediately forces reset values. Any pending key is lost; no overrun pulse.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, a held-scan counter runs.
  - The first re-emit of the same code happens at REPEAT_DELAY scans, then every REPEAT_RATE scans while held.
  - Each re-emit follows the normal emit rules, including overrun.
  - The counter clears on leaving HELD.
- KEYPAD_REPEAT_EN undefined: HELD only waits for release, and REPEAT_* are unused.

## Structure
- keypad_pkg holds:
  - the state enum (IDLE, DEBOUNCE, HELD, RELEASE)
  - the key_code_t typedef (logic [3:0])
  - the one-hot-low column constant array {4'hE, 4'hD, 4'hB, 4'h7}
- One sub-module, keypad_sync: a parameterized-width 2-flop synchronizer with async reset to all-ones (idle rows).

## Test plan
Bench uses SCAN_DIV=4 and DEBOUNCE_SCANS=2 (full scan = 16 clocks).
- Reset check: assert rst mid-scan -> col_out = 4'hE, key_valid = 0, key_overrun = 0 immediately.
- Single press: hold row 2 low while col_out = 4'hB (column 2) for 3 scans, key_ready = 1 -> key_code = 4'hA, key_valid high for exactly 1 cycle, exactly once.
- Bounce: toggle row 0 every 5 clocks during column 1 -> no key_valid; then hold stable for 2 scans -> key_code = 4'h1.
- Backpressure: key_ready = 0; press 4'h5, release, press 4'h6 -> key_valid held with 4'h5, one key_overrun pulse at the second emit; then key_ready = 1 -> key_valid falls next cycle.
- Simultaneous keys: rows 3 and 1 pressed in column 0 -> key_code = 4'h4 (lowest row wins); releasing one key emits nothing new.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY=3, REPEAT_RATE=2: hold 4'hF for 9 scans -> emits at acceptance, then 3 and 5 and 7 scans later; nothing after release.
